regfile_wb_scheduler: RTL and testbench
=======================================

Name: regfile_wb_scheduler

Overview:
Scheduler in front of the 16 x 19-bit register file.
- Keeps a per-register scoreboard of pending writes and gates instruction issue on RAW/WAW hazards.
- Arbitrates the ALU and memory-load writeback requesters onto the register file's single write port, round-robin.
- Sits between decode/issue and the register file. Drives the regwrite/rd/write_data inputs of the register file.

Parameters:
DATA_W, 19, register data width
NREG, 16, number of architectural registers (r0 hardwired zero)
AW, 4, register index width (log2 NREG)
CNT_W, 16, width of stall cycle counter

Ports:
clk  in  1  clock
reset  in  1  asynchronous, active-high reset
issue_valid  in  1  decode presents an instruction
issue_rs1  in  AW  source register 1
issue_rs2  in  AW  source register 2
issue_rd  in  AW  destination register
issue_wb  in  1  instruction writes issue_rd
issue_ready  out  1  no hazard; instruction accepted when issue_valid && issue_ready
alu_wb_valid  in  1  ALU writeback request
alu_wb_rd  in  AW  ALU destination
alu_wb_data  in  DATA_W  ALU result
alu_wb_ready  out  1  ALU request granted this cycle
mem_wb_valid  in  1  load writeback request
mem_wb_rd  in  AW  load destination
mem_wb_data  in  DATA_W  load data
mem_wb_ready  out  1  load request granted this cycle
rf_regwrite  out  1  register file write enable
rf_rd  out  AW  register file write index
rf_write_data  out  DATA_W  register file write data
busy_mask  out  NREG  scoreboard, bit i = write pending to ri
stall_count  out  CNT_W  saturating count of hazard-stall cycles
wb_err  out  1  sticky: writeback to a non-busy nonzero register

Behaviour:
Reset (async, immediate) clears all state:
- busy_mask, rf_regwrite, rf_rd, rf_write_data, stall_count, wb_err = 0.
- rr_ptr = 0 (ALU preferred).
- A write latched in the output register is discarded; outstanding requesters must re-request after reset.

Issue gating (combinational):
- issue_ready = !busy[rs1] && !busy[rs2] && !(issue_wb && busy[rd]).
- busy[0] is constantly 0.
- issue_ready is independent of issue_valid.

Scoreboard set:
- On an edge with issue_valid && issue_ready && issue_wb && issue_rd != 0, busy[issue_rd] <= 1.

Writeback arbitration (combinational grant):
- Only one valid requester: it is granted.
- Both valid: the requester selected by rr_ptr is granted (0 = ALU, 1 = MEM).
- After any grant, rr_ptr <= index of the non-granted requester.
- No request: rr_ptr holds.
- alu_wb_ready / mem_wb_ready are high only for the granted requester, only when its valid is high.
- Exactly zero or one grant per cycle. The output stage never back-pressures.

Write output stage (1-cycle latency):
- On a grant edge: rf_regwrite <= (granted_rd != 0); rf_rd <= granted_rd; rf_write_data <= granted_data.
- No grant: rf_regwrite <= 0; rf_rd and rf_write_data hold.

Scoreboard clear:
- On an edge where rf_regwrite == 1, busy[rf_rd] <= 0.
- The register file commits on that same edge, so a dependent instruction sees issue_ready in the cycle after commit and reads the new value.
- If a set and a clear hit the same register on one edge, the set wins. Normally impossible, since issue is blocked while the register is busy.

Error and stall bookkeeping:
- wb_err is set on a grant to rd != 0 whose busy bit is 0. It stays set until reset. The write still proceeds.
- Writeback to rd = 0 is granted, produces no rf write and no busy change, and does not set wb_err.
- stall_count increments on each edge with issue_valid && !issue_ready and saturates at 2^CNT_W - 1.

Test Plan:
- Reset, then issue rd=3, rs1=1, rs2=2, wb=1 -> busy_mask=0x0008 next cycle. A second issue reading rs1=3 holds issue_ready=0 and stall_count counts 1, 2, 3...
- ALU wb rd=3, data=0x7FFFF -> alu_wb_ready=1 same cycle; next cycle rf_regwrite=1, rf_rd=3, rf_write_data=0x7FFFF; busy[3]=0 the cycle after; stalled issue then accepted.
- Issue rd=4 and rd=5 (wb=1), then ALU(rd=4) and MEM(rd=5) valid together for 2 cycles -> cycle 1 grants ALU (rr_ptr=0), cycle 2 grants MEM; rf writes r4 then r5 on consecutive cycles.
- Issue rd=0, wb=1 -> busy_mask stays 0. ALU wb rd=0 -> alu_wb_ready=1, rf_regwrite stays 0, wb_err stays 0.
- MEM wb rd=7 with busy[7]=0 -> write to r7 occurs and wb_err=1 sticky. Assert reset while rf_regwrite=1 -> rf_regwrite=0 and busy_mask=0 immediately, without waiting for a clk edge.
- Hold issue_valid with hazard for 70000 cycles (CNT_W=16) -> stall_count saturates at 0xFFFF.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// Hazard scoreboard, round-robin ALU/MEM writeback arbiter and 1-cycle register
// file write stage. Grants are combinational and the write stage never back-pressures.
module regfile_wb_scheduler #(
  parameter int DATA_W = 19,
  parameter int NREG   = 16,
  parameter int AW     = 4,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              issue_valid,
  input  logic [AW-1:0]     issue_rs1,
  input  logic [AW-1:0]     issue_rs2,
  input  logic [AW-1:0]     issue_rd,
  input  logic              issue_wb,
  output logic              issue_ready,
  input  logic              alu_wb_valid,
  input  logic [AW-1:0]     alu_wb_rd,
  input  logic [DATA_W-1:0] alu_wb_data,
  output logic              alu_wb_ready,
  input  logic              mem_wb_valid,
  input  logic [AW-1:0]     mem_wb_rd,
  input  logic [DATA_W-1:0] mem_wb_data,
  output logic              mem_wb_ready,
  output logic              rf_regwrite,
  output logic [AW-1:0]     rf_rd,
  output logic [DATA_W-1:0] rf_write_data,
  output logic [NREG-1:0]   busy_mask,
  output logic [CNT_W-1:0]  stall_count,
  output logic              wb_err
);

  localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  logic [NREG-1:0]   busy_q, busy_d;
  logic              rr_ptr_q, rr_ptr_d;
  logic              rf_regwrite_q, rf_regwrite_d;
  logic [AW-1:0]     rf_rd_q, rf_rd_d;
  logic [DATA_W-1:0] rf_write_data_q, rf_write_data_d;
  logic [CNT_W-1:0]  stall_count_q, stall_count_d;
  logic              wb_err_q, wb_err_d;

  logic              issue_fire;
  logic              any_gnt;
  logic [AW-1:0]     gnt_rd;
  logic [DATA_W-1:0] gnt_data;

  always_comb begin
    issue_ready = !busy_q[issue_rs1] && !busy_q[issue_rs2] &&
                  !(issue_wb && busy_q[issue_rd]);
    issue_fire  = issue_valid && issue_ready;

    // rr_ptr only matters when both requesters collide
    alu_wb_ready = alu_wb_valid && (!mem_wb_valid || !rr_ptr_q);
    mem_wb_ready = mem_wb_valid && (!alu_wb_valid ||  rr_ptr_q);
    any_gnt      = alu_wb_ready || mem_wb_ready;
    gnt_rd       = mem_wb_ready ? mem_wb_rd   : alu_wb_rd;
    gnt_data     = mem_wb_ready ? mem_wb_data : alu_wb_data;
  end

  always_comb begin
    rr_ptr_d        = rr_ptr_q;
    rf_regwrite_d   = 1'b0;
    rf_rd_d         = rf_rd_q;
    rf_write_data_d = rf_write_data_q;
    wb_err_d        = wb_err_q;
    stall_count_d   = stall_count_q;
    busy_d          = busy_q;

    if (alu_wb_ready) rr_ptr_d = 1'b1;
    if (mem_wb_ready) rr_ptr_d = 1'b0;

    if (any_gnt) begin
      rf_regwrite_d   = (gnt_rd != '0);
      rf_rd_d         = gnt_rd;
      rf_write_data_d = gnt_data;
      if (gnt_rd != '0 && !busy_q[gnt_rd]) wb_err_d = 1'b1;
    end

    if (issue_valid && !issue_ready && stall_count_q != CNT_MAX)
      stall_count_d = stall_count_q + CNT_ONE;

    // clear first so a same-edge set on the same register wins
    if (rf_regwrite_q) busy_d[rf_rd_q] = 1'b0;
    if (issue_fire && issue_wb && issue_rd != '0) busy_d[issue_rd] = 1'b1;
    busy_d[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy_q          <= '0;
      rr_ptr_q        <= 1'b0;
      rf_regwrite_q   <= 1'b0;
      rf_rd_q         <= '0;
      rf_write_data_q <= '0;
      stall_count_q   <= '0;
      wb_err_q        <= 1'b0;
    end else begin
      busy_q          <= busy_d;
      rr_ptr_q        <= rr_ptr_d;
      rf_regwrite_q   <= rf_regwrite_d;
      rf_rd_q         <= rf_rd_d;
      rf_write_data_q <= rf_write_data_d;
      stall_count_q   <= stall_count_d;
      wb_err_q        <= wb_err_d;
    end
  end

  assign rf_regwrite   = rf_regwrite_q;
  assign rf_rd         = rf_rd_q;
  assign rf_write_data = rf_write_data_q;
  assign busy_mask     = busy_q;
  assign stall_count   = stall_count_q;
  assign wb_err        = wb_err_q;

endmodule

// File: tb/tb_regfile_wb_scheduler.sv
// Bench for regfile_wb_scheduler: directed scenarios plus random traffic, all
// checked every cycle against a behavioural scoreboard/arbiter model.
module tb_regfile_wb_scheduler;

  localparam int DW = 19;
  localparam int NR = 16;
  localparam int AW = 4;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          reset;
  logic          issue_valid, issue_wb;
  logic [AW-1:0] issue_rs1, issue_rs2, issue_rd;
  logic          issue_ready;
  logic          alu_wb_valid, alu_wb_ready;
  logic [AW-1:0] alu_wb_rd;
  logic [DW-1:0] alu_wb_data;
  logic          mem_wb_valid, mem_wb_ready;
  logic [AW-1:0] mem_wb_rd;
  logic [DW-1:0] mem_wb_data;
  logic          rf_regwrite;
  logic [AW-1:0] rf_rd;
  logic [DW-1:0] rf_write_data;
  logic [NR-1:0] busy_mask;
  logic [CW-1:0] stall_count;
  logic          wb_err;

  always #5 clk = ~clk;

  regfile_wb_scheduler #(.DATA_W(DW), .NREG(NR), .AW(AW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset),
    .issue_valid(issue_valid), .issue_rs1(issue_rs1), .issue_rs2(issue_rs2),
    .issue_rd(issue_rd), .issue_wb(issue_wb), .issue_ready(issue_ready),
    .alu_wb_valid(alu_wb_valid), .alu_wb_rd(alu_wb_rd), .alu_wb_data(alu_wb_data),
    .alu_wb_ready(alu_wb_ready),
    .mem_wb_valid(mem_wb_valid), .mem_wb_rd(mem_wb_rd), .mem_wb_data(mem_wb_data),
    .mem_wb_ready(mem_wb_ready),
    .rf_regwrite(rf_regwrite), .rf_rd(rf_rd), .rf_write_data(rf_write_data),
    .busy_mask(busy_mask), .stall_count(stall_count), .wb_err(wb_err)
  );

  int vectors = 0;
  int miscompares = 0;

  // model state: pending-write set, preferred requester, last write, counters
  bit m_busy [NR];
  bit m_pref_mem;
  bit m_wen;
  int m_wrd;
  int m_wdata;
  int m_stall;
  bit m_err;

  function automatic void model_reset();
    for (int i = 0; i < NR; i++) m_busy[i] = 1'b0;
    m_pref_mem = 1'b0;
    m_wen = 1'b0; m_wrd = 0; m_wdata = 0; m_stall = 0; m_err = 1'b0;
  endfunction

  function automatic bit exp_ready();
    return !m_busy[issue_rs1] && !m_busy[issue_rs2] && !(issue_wb && m_busy[issue_rd]);
  endfunction

  // 0 = none, 1 = ALU, 2 = MEM
  function automatic int exp_winner();
    if (alu_wb_valid && mem_wb_valid) return m_pref_mem ? 2 : 1;
    if (alu_wb_valid) return 1;
    if (mem_wb_valid) return 2;
    return 0;
  endfunction

  function automatic logic [NR-1:0] exp_mask();
    logic [NR-1:0] m;
    for (int i = 0; i < NR; i++) m[i] = m_busy[i];
    return m;
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, got, exp);
    end
  endtask

  task automatic check_outputs();
    int w;
    w = exp_winner();
    chk("issue_ready", 32'(issue_ready), 32'(exp_ready()));
    chk("alu_wb_ready", 32'(alu_wb_ready), 32'(w == 1));
    chk("mem_wb_ready", 32'(mem_wb_ready), 32'(w == 2));
    chk("rf_regwrite", 32'(rf_regwrite), 32'(m_wen));
    chk("rf_rd", 32'(rf_rd), 32'(m_wrd[AW-1:0]));
    chk("rf_write_data", 32'(rf_write_data), 32'(m_wdata[DW-1:0]));
    chk("busy_mask", 32'(busy_mask), 32'(exp_mask()));
    chk("stall_count", 32'(stall_count), 32'(m_stall));
    chk("wb_err", 32'(wb_err), 32'(m_err));
  endtask

  // one clock: compare, predict the edge, advance; returns at the next negedge
  task automatic do_cycle();
    bit nb [NR];
    bit n_pref, n_wen, n_err, rdy;
    int n_wrd, n_wdata, n_stall, w, grd, gdata;
    #1;
    if (reset) model_reset();
    check_outputs();
    rdy = exp_ready();
    w = exp_winner();
    grd   = (w == 2) ? int'(mem_wb_rd)   : int'(alu_wb_rd);
    gdata = (w == 2) ? int'(mem_wb_data) : int'(alu_wb_data);
    for (int i = 0; i < NR; i++) nb[i] = m_busy[i];
    n_pref = m_pref_mem; n_wen = 1'b0; n_wrd = m_wrd; n_wdata = m_wdata;
    n_err = m_err; n_stall = m_stall;
    if (w != 0) begin
      n_pref  = (w == 1);
      n_wen   = (grd != 0);
      n_wrd   = grd;
      n_wdata = gdata;
      if (grd != 0 && !m_busy[grd]) n_err = 1'b1;
    end
    if (issue_valid && !rdy && n_stall < 65535) n_stall = n_stall + 1;
    if (m_wen) nb[m_wrd] = 1'b0;
    if (issue_valid && rdy && issue_wb && issue_rd != 0) nb[issue_rd] = 1'b1;
    @(posedge clk);
    if (reset) model_reset();
    else begin
      for (int i = 0; i < NR; i++) m_busy[i] = nb[i];
      m_pref_mem = n_pref; m_wen = n_wen; m_wrd = n_wrd; m_wdata = n_wdata;
      m_err = n_err; m_stall = n_stall;
    end
    @(negedge clk);
  endtask

  task automatic set_issue(input bit v, input int rs1, input int rs2, input int rd, input bit wb);
    issue_valid = v; issue_rs1 = AW'(rs1); issue_rs2 = AW'(rs2);
    issue_rd = AW'(rd); issue_wb = wb;
  endtask

  task automatic set_alu(input bit v, input int rd, input int data);
    alu_wb_valid = v; alu_wb_rd = AW'(rd); alu_wb_data = DW'(data);
  endtask

  task automatic set_mem(input bit v, input int rd, input int data);
    mem_wb_valid = v; mem_wb_rd = AW'(rd); mem_wb_data = DW'(data);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    do_cycle();
    reset = 1'b0;
  endtask

  function automatic int pick_rd();
    int q[$];
    for (int i = 1; i < NR; i++) if (m_busy[i]) q.push_back(i);
    if (q.size() > 0 && $urandom_range(0, 99) < 85) return q[$urandom_range(0, q.size() - 1)];
    return int'($urandom_range(0, NR - 1));
  endfunction

  initial begin
    model_reset();
    reset = 1'b1;
    set_issue(0, 0, 0, 0, 0);
    set_alu(0, 0, 0);
    set_mem(0, 0, 0);
    @(negedge clk);
    do_cycle();
    do_cycle();
    reset = 1'b0;
    chk("rst_busy", 32'(busy_mask), 32'h0);
    chk("rst_regwrite", 32'(rf_regwrite), 32'h0);
    chk("rst_stall", 32'(stall_count), 32'h0);
    chk("rst_err", 32'(wb_err), 32'h0);

    // RAW hazard on r3 and stall counting
    set_issue(1, 1, 2, 3, 1);
    do_cycle();
    chk("busy_r3", 32'(busy_mask), 32'h0008);
    set_issue(1, 3, 0, 6, 1);
    #1 chk("raw_blocked", 32'(issue_ready), 32'h0);
    do_cycle();
    chk("stall_1", 32'(stall_count), 32'd1);
    do_cycle();
    chk("stall_2", 32'(stall_count), 32'd2);
    do_cycle();
    chk("stall_3", 32'(stall_count), 32'd3);

    // ALU writeback to r3 unblocks the stalled issue
    set_alu(1, 3, 'h7FFFF);
    #1 chk("alu_grant", 32'(alu_wb_ready), 32'h1);
    do_cycle();
    set_alu(0, 0, 0);
    chk("wr3_en", 32'(rf_regwrite), 32'h1);
    chk("wr3_rd", 32'(rf_rd), 32'd3);
    chk("wr3_data", 32'(rf_write_data), 32'h7FFFF);
    chk("still_busy", 32'(busy_mask), 32'h0008);
    do_cycle();
    chk("r3_cleared", 32'(busy_mask), 32'h0000);
    chk("issue_unblocked", 32'(issue_ready), 32'h1);
    do_cycle();
    chk("busy_r6", 32'(busy_mask), 32'h0040);
    set_issue(0, 0, 0, 0, 0);

    // round robin from a fresh pointer
    pulse_reset();
    set_issue(1, 0, 0, 4, 1);
    do_cycle();
    set_issue(1, 0, 0, 5, 1);
    do_cycle();
    set_issue(0, 0, 0, 0, 0);
    set_alu(1, 4, 'h11111);
    set_mem(1, 5, 'h22222);
    #1 chk("rr1_alu", 32'(alu_wb_ready), 32'h1);
    chk("rr1_mem", 32'(mem_wb_ready), 32'h0);
    do_cycle();
    chk("rr1_rd", 32'(rf_rd), 32'd4);
    chk("rr1_data", 32'(rf_write_data), 32'h11111);
    #1 chk("rr2_mem", 32'(mem_wb_ready), 32'h1);
    chk("rr2_alu", 32'(alu_wb_ready), 32'h0);
    do_cycle();
    chk("rr2_rd", 32'(rf_rd), 32'd5);
    chk("rr2_data", 32'(rf_write_data), 32'h22222);
    set_alu(0, 0, 0);
    set_mem(0, 0, 0);
    do_cycle();
    do_cycle();

    // r0 is never tracked nor written
    set_issue(1, 0, 0, 0, 1);
    do_cycle();
    set_issue(0, 0, 0, 0, 0);
    chk("r0_busy", 32'(busy_mask), 32'h0);
    set_alu(1, 0, 'h1234);
    #1 chk("r0_grant", 32'(alu_wb_ready), 32'h1);
    do_cycle();
    set_alu(0, 0, 0);
    chk("r0_nowrite", 32'(rf_regwrite), 32'h0);
    chk("r0_noerr", 32'(wb_err), 32'h0);

    // stray load writeback to r7, then asynchronous reset mid-cycle
    set_mem(1, 7, 'h12345);
    set_issue(1, 0, 0, 9, 1);
    do_cycle();
    set_mem(0, 0, 0);
    set_issue(0, 0, 0, 0, 0);
    chk("r7_write", 32'(rf_regwrite), 32'h1);
    chk("r7_rd", 32'(rf_rd), 32'd7);
    chk("r7_err", 32'(wb_err), 32'h1);
    chk("r9_busy", 32'(busy_mask), 32'h0200);
    do_cycle();
    chk("err_sticky", 32'(wb_err), 32'h1);
    set_mem(1, 7, 'h0ABCD);
    do_cycle();
    set_mem(0, 0, 0);
    #2 reset = 1'b1;
    #1 chk("async_regwrite", 32'(rf_regwrite), 32'h0);
    chk("async_busy", 32'(busy_mask), 32'h0);
    chk("async_err", 32'(wb_err), 32'h0);
    model_reset();
    @(negedge clk);
    do_cycle();
    reset = 1'b0;

    // random traffic
    for (int n = 0; n < 3000; n++) begin
      set_issue($urandom_range(0, 9) < 7, int'($urandom_range(0, NR - 1)),
                int'($urandom_range(0, NR - 1)), int'($urandom_range(0, NR - 1)),
                $urandom_range(0, 3) != 0);
      set_alu($urandom_range(0, 1) == 1, pick_rd(), int'($urandom_range(0, (1 << DW) - 1)));
      set_mem($urandom_range(0, 1) == 1, pick_rd(), int'($urandom_range(0, (1 << DW) - 1)));
      do_cycle();
    end
    set_alu(0, 0, 0);
    set_mem(0, 0, 0);

    // stall counter saturation
    pulse_reset();
    set_issue(1, 0, 0, 3, 1);
    do_cycle();
    set_issue(1, 3, 0, 8, 1);
    for (int n = 0; n < 70000; n++) do_cycle();
    chk("stall_sat", 32'(stall_count), 32'hFFFF);
    set_issue(0, 0, 0, 0, 0);
    do_cycle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
